regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the fixed two-port RegisterFile in the CPU datapath. It provides NRD registered read ports and NWR write ports. It adds configurable write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard used by issue logic to track pending writebacks.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 32, number of registers
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH
NRD, 2, number of read ports
NWR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 always reads 0; writes and reservations to it are ignored
BYPASS, 1, 1 = a same-cycle write is forwarded to the read result

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_en  in  NRD  read enable per port
rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  out  NRD*WIDTH  registered read data, packed the same way as rd_addr
rd_busy  out  NRD  registered busy bit of the register read on each port
wr_en  in  NWR  write enable per port
wr_addr  in  NWR*ADDR_W  write addresses
wr_data  in  NWR*WIDTH  write data
rsv_en  in  1  reserve request: mark a register busy
rsv_addr  in  ADDR_W  register to reserve
busy  out  DEPTH  live scoreboard, bit k = register k has a pending writeback

Behaviour:
- Reset (rst low, asynchronous): all registers, busy, rd_data and rd_busy go to 0. All outputs remain 0 until the first rising edge after rst is released.
- Write: on a rising edge with wr_en[j] set, reg[wr_addr[j]] <= wr_data[j].
  - If several ports write the same address in one cycle, the highest-index port wins.
  - Writes to addresses >= DEPTH are ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Read: 1-cycle latency. On a rising edge with rd_en[i] set, rd_data[i] loads the value of reg[rd_addr[i]].
  - With rd_en[i] low, rd_data[i] and rd_busy[i] hold their previous values.
  - An address >= DEPTH reads 0, with busy 0.
  - With ZERO_REG=1, address 0 reads 0, with busy 0.
- Bypass:
  - BYPASS=1: if a write to the read address is active in the same cycle, rd_data returns the winning write data (the post-edge value).
  - BYPASS=0: rd_data returns the pre-edge register contents.
- Scoreboard (evaluated per register at each edge):
  - rsv_en set with a valid rsv_addr: busy[rsv_addr] <= 1.
  - Any write to register k clears busy[k].
  - Reserve and write to the same register in the same cycle: reserve wins and busy stays 1, because a new producer has been issued.
  - With ZERO_REG=1, reserving register 0 is ignored.
  - busy is a direct register output (no extra latency).
- rd_busy[i]:
  - BYPASS=1: the post-edge busy state of the register read.
  - BYPASS=0: the pre-edge busy state.
  - It is always captured together with rd_data[i].
- Independent ports: reads and writes on different ports are fully concurrent. No port stalls or back-pressures another.

Test Plan:
- Reset mid-operation: write 0xABCDEF00 to r3, then pull rst low between clock edges → rd_data, rd_busy and busy drop to 0 immediately; a later read of r3 returns 0x00000000.
- Basic write/read: write 0xABCDEF00 to r1 on port 0; next cycle read r1 on ports 0 and 1 → both rd_data show 0xABCDEF00 one edge later; rd_en low afterwards → values hold.
- Write conflict: port 0 writes 0x11111111 and port 1 writes 0x22222222 to r5 in the same cycle → a subsequent read of r5 returns 0x22222222.
- Bypass: r7 = 0x0; in the same cycle write 0x12345678 to r7 and read r7 → BYPASS=1 returns 0x12345678, BYPASS=0 returns 0x00000000.
- Zero register: ZERO_REG=1; write 0xFFFFFFFF to r0 and reserve r0 → read r0 returns 0 and busy[0] stays 0; with ZERO_REG=0 the read returns 0xFFFFFFFF.
- Scoreboard: reserve r4 → busy[4]=1 after the edge. Write r4 → busy[4]=0. Reserve and write r4 in the same cycle → busy[4] stays 1 and r4 holds the written data. A read of r4 while busy reports rd_busy=1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// reservation request and the live busy scoreboard.
interface regfile_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*WIDTH-1:0]  rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*WIDTH-1:0]  wr_data;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_addr;
    logic [DEPTH-1:0]      busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, optional
// write-to-read bypass, optional hardwired zero register and a per-register
// busy scoreboard for tracking pending writebacks.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    logic [WIDTH-1:0]     regs     [DEPTH];
    logic [WIDTH-1:0]     regs_nxt [DEPTH];
    logic [DEPTH-1:0]     wr_hit;
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_nxt;
    logic [NRD*WIDTH-1:0] rd_data_q;
    logic [NRD*WIDTH-1:0] rd_data_nxt;
    logic [NRD-1:0]       rd_busy_q;
    logic [NRD-1:0]       rd_busy_nxt;
    logic [ADDR_W-1:0]    ra;

    // An address names a real, writable/readable register: inside DEPTH and
    // not the hardwired zero register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Post-edge register and scoreboard state; later write ports override
    // earlier ones, and a reservation overrides a writeback clear.
    always_comb begin
        wr_hit   = '0;
        busy_nxt = busy_q;
        for (int k = 0; k < DEPTH; k++) begin
            regs_nxt[k] = regs[k];
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && (32'(bus.wr_addr[j*ADDR_W +: ADDR_W]) == k)
                    && !((ZERO_REG != 0) && (k == 0))) begin
                    regs_nxt[k] = bus.wr_data[j*WIDTH +: WIDTH];
                    wr_hit[k]   = 1'b1;
                end
            end
            if (bus.rsv_en && (32'(bus.rsv_addr) == k)
                && !((ZERO_REG != 0) && (k == 0))) begin
                busy_nxt[k] = 1'b1;
            end else if (wr_hit[k]) begin
                busy_nxt[k] = 1'b0;
            end
        end
    end

    // Read-port capture values; disabled ports hold, dead addresses read zero.
    always_comb begin
        rd_data_nxt = rd_data_q;
        rd_busy_nxt = rd_busy_q;
        ra          = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_en[i]) begin
                ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
                if (addr_live(ra)) begin
                    if (BYPASS != 0) begin
                        rd_data_nxt[i*WIDTH +: WIDTH] = regs_nxt[ra];
                        rd_busy_nxt[i]                = busy_nxt[ra];
                    end else begin
                        rd_data_nxt[i*WIDTH +: WIDTH] = regs[ra];
                        rd_busy_nxt[i]                = busy_q[ra];
                    end
                end else begin
                    rd_data_nxt[i*WIDTH +: WIDTH] = '0;
                    rd_busy_nxt[i]                = 1'b0;
                end
            end
        end
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= regs_nxt[k];
            end
            busy_q    <= busy_nxt;
            rd_data_q <= rd_data_nxt;
            rd_busy_q <= rd_busy_nxt;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg + bypass, and a shallower
// plain/no-bypass one) share one stimulus stream and are compared against
// a simple array model of the register file after every edge.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int tests;
    int failures;

    // Model state per configuration: 0 = DUT A, 1 = DUT B.
    logic [31:0] mreg  [2][32];
    logic [31:0] mbusy [2];
    logic [63:0] erd   [2];
    logic [1:0]  erdb  [2];

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NRD(2), .NWR(2)) bus_a ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .NRD(2), .NWR(2)) bus_b ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NRD(2), .NWR(2),
                 .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_mp #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .NRD(2), .NWR(2),
                 .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.rd_en    = rd_en;
    assign bus_a.rd_addr  = rd_addr;
    assign bus_a.wr_en    = wr_en;
    assign bus_a.wr_addr  = wr_addr;
    assign bus_a.wr_data  = wr_data;
    assign bus_a.rsv_en   = rsv_en;
    assign bus_a.rsv_addr = rsv_addr;
    assign bus_b.rd_en    = rd_en;
    assign bus_b.rd_addr  = rd_addr;
    assign bus_b.wr_en    = wr_en;
    assign bus_b.wr_addr  = wr_addr;
    assign bus_b.wr_data  = wr_data;
    assign bus_b.rsv_en   = rsv_en;
    assign bus_b.rsv_addr = rsv_addr;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 32; k++) mreg[c][k] = '0;
            mbusy[c] = '0;
            erd[c]   = '0;
            erdb[c]  = '0;
        end
    endtask

    // Apply one clock edge worth of the current inputs to the model.
    task automatic model_step();
        int          depth;
        bit          zr;
        bit          byp;
        int          a;
        logic [31:0] nreg [32];
        logic [31:0] nbusy;
        for (int c = 0; c < 2; c++) begin
            depth = (c == 0) ? 32 : 24;
            zr    = (c == 0);
            byp   = (c == 0);
            for (int k = 0; k < 32; k++) nreg[k] = mreg[c][k];
            nbusy = mbusy[c];
            for (int j = 0; j < 2; j++) begin
                a = int'(wr_addr[j*5 +: 5]);
                if (wr_en[j] && a < depth && !(zr && a == 0)) begin
                    nreg[a]  = wr_data[j*32 +: 32];
                    nbusy[a] = 1'b0;
                end
            end
            a = int'(rsv_addr);
            if (rsv_en && a < depth && !(zr && a == 0)) nbusy[a] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (rd_en[i]) begin
                    a = int'(rd_addr[i*5 +: 5]);
                    if (a < depth && !(zr && a == 0)) begin
                        erd[c][i*32 +: 32] = byp ? nreg[a] : mreg[c][a];
                        erdb[c][i]         = byp ? nbusy[a] : mbusy[c][a];
                    end else begin
                        erd[c][i*32 +: 32] = '0;
                        erdb[c][i]         = 1'b0;
                    end
                end
            end
            for (int k = 0; k < 32; k++) mreg[c][k] = nreg[k];
            mbusy[c] = nbusy;
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ":a_rd_data"}, bus_a.rd_data, erd[0]);
        check({phase, ":a_rd_busy"}, 64'(bus_a.rd_busy), 64'(erdb[0]));
        check({phase, ":a_busy"},    64'(bus_a.busy), 64'(mbusy[0]));
        check({phase, ":b_rd_data"}, bus_b.rd_data, erd[1]);
        check({phase, ":b_rd_busy"}, 64'(bus_b.rd_busy), 64'(erdb[1]));
        check({phase, ":b_busy"},    64'(bus_b.busy), 64'(mbusy[1][23:0]));
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic step(input string phase);
        model_step();
        @(posedge clk);
        #1;
        check_all(phase);
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en[port]             = 1'b1;
        wr_addr[port*5 +: 5]    = a;
        wr_data[port*32 +: 32]  = d;
    endtask

    task automatic rd(input int port, input logic [4:0] a);
        rd_en[port]          = 1'b1;
        rd_addr[port*5 +: 5] = a;
    endtask

    initial begin
        tests = 0;
        failures = 0;
        rst = 1'b0;
        idle();
        model_reset();

        // Reset state, then release in the low phase: still zero before an edge.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("released");

        // Basic write then dual-port read, then hold with rd_en low.
        idle(); wr(0, 5'd1, 32'hABCDEF00); step("basic_wr");
        idle(); rd(0, 5'd1); rd(1, 5'd1); step("basic_rd");
        check("basic_const", bus_a.rd_data, {32'hABCDEF00, 32'hABCDEF00});
        idle(); wr(0, 5'd1, 32'h5555AAAA); step("basic_hold");
        check("hold_const", bus_a.rd_data, {32'hABCDEF00, 32'hABCDEF00});

        // Two ports write r5 in the same cycle: port 1 wins.
        idle(); wr(0, 5'd5, 32'h11111111); wr(1, 5'd5, 32'h22222222); step("conflict_wr");
        idle(); rd(0, 5'd5); step("conflict_rd");
        check("conflict_const", 64'(bus_a.rd_data[31:0]), 64'h22222222);

        // Same-cycle write and read of r7.
        idle(); wr(0, 5'd7, 32'h12345678); rd(0, 5'd7); step("bypass");
        check("bypass_on", 64'(bus_a.rd_data[31:0]), 64'h12345678);
        check("bypass_off", 64'(bus_b.rd_data[31:0]), 64'h0);

        // Write and reserve r0.
        idle(); wr(0, 5'd0, 32'hFFFFFFFF); rsv_en = 1'b1; rsv_addr = 5'd0; step("zero_wr");
        check("zero_busy_a", 64'(bus_a.busy[0]), 64'h0);
        idle(); rd(0, 5'd0); step("zero_rd");
        check("zero_rd_a", 64'(bus_a.rd_data[31:0]), 64'h0);
        check("zero_rd_b", 64'(bus_b.rd_data[31:0]), 64'hFFFFFFFF);

        // Scoreboard: reserve, read while busy, clear by write, reserve+write.
        idle(); rsv_en = 1'b1; rsv_addr = 5'd4; step("sb_rsv");
        check("sb_rsv_busy", 64'(bus_a.busy[4]), 64'h1);
        idle(); rd(1, 5'd4); step("sb_rd_busy");
        check("sb_rd_busy_const", 64'(bus_a.rd_busy[1]), 64'h1);
        idle(); wr(1, 5'd4, 32'h0000C0DE); step("sb_clear");
        check("sb_clear_busy", 64'(bus_a.busy[4]), 64'h0);
        idle(); wr(0, 5'd4, 32'h44444444); rsv_en = 1'b1; rsv_addr = 5'd4; step("sb_both");
        check("sb_both_busy", 64'(bus_a.busy[4]), 64'h1);
        idle(); rd(0, 5'd4); step("sb_both_rd");
        check("sb_both_data", 64'(bus_a.rd_data[31:0]), 64'h44444444);

        // Randomized traffic, addresses biased low to provoke collisions;
        // DUT B also sees addresses beyond its depth.
        for (int n = 0; n < 300; n++) begin
            rd_en    = 2'($urandom_range(0, 3));
            wr_en    = 2'($urandom_range(0, 3));
            rsv_en   = 1'($urandom_range(0, 1));
            for (int p = 0; p < 2; p++) begin
                rd_addr[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                                 : 5'($urandom_range(0, 31));
                wr_addr[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                                 : 5'($urandom_range(0, 31));
                wr_data[p*32 +: 32] = $urandom;
            end
            rsv_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                   : 5'($urandom_range(0, 31));
            step("random");
        end

        // Reset between edges after writing r3.
        idle(); wr(0, 5'd3, 32'hABCDEF00); rsv_en = 1'b1; rsv_addr = 5'd9; step("mid_wr");
        idle(); rd(0, 5'd3); step("mid_rd");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        check("mid_reset_rd", bus_a.rd_data, 64'h0);
        check("mid_reset_busy", 64'(bus_a.busy), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(); rd(0, 5'd3); rd(1, 5'd3); step("post_reset_rd");
        check("post_reset_r3", 64'(bus_a.rd_data[31:0]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
